// File: rtl/hamming_secded_decoder_pipe_if.sv
// Stream-side bundle for the pipelined SECDED decoder: codeword input, decoded
// result output, and the error counter controls/observations.
interface hamming_secded_decoder_pipe_if #(
    parameter int DATA_W     = 11,
    parameter int PAR_W      = 4,
    parameter int EXT_PARITY = 1,
    parameter int CNT_W      = 16
);
    localparam int HW   = DATA_W + PAR_W;
    localparam int CW_W = HW + EXT_PARITY;

    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   codeword_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              err_corrected;
    logic              err_uncorrectable;
    logic [PAR_W-1:0]  err_pos;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_count;
    logic [CNT_W-1:0]  uncorr_count;

    modport master (
        output in_valid, codeword_in, out_ready, cnt_clr,
        input  in_ready, out_valid, data_out, err_corrected, err_uncorrectable,
               err_pos, corr_count, uncorr_count
    );

    modport slave (
        input  in_valid, codeword_in, out_ready, cnt_clr,
        output in_ready, out_valid, data_out, err_corrected, err_uncorrectable,
               err_pos, corr_count, uncorr_count
    );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage pipelined extended-Hamming (SECDED) decoder with valid/ready flow
// control on both sides and saturating corrected/uncorrectable word counters.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W     = 11,
    parameter int PAR_W      = 4,
    parameter int EXT_PARITY = 1,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    hamming_secded_decoder_pipe_if.slave bus
);
    localparam int HW = DATA_W + PAR_W;
    localparam logic [PAR_W-1:0] HW_POS = PAR_W'(HW);

    generate
        if ((2 ** PAR_W) < HW + 1) begin : g_par_w_check
            $error("PAR_W too small: 2**PAR_W must be >= DATA_W+PAR_W+1");
        end
    endgenerate

    // Hamming position (1-based) holding data bit d: d-th non-power-of-two slot.
    function automatic int data_position(input int d);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= HW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == d) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [HW-1:0] syndrome_mask(input int j);
        logic [HW-1:0] m;
        m = '0;
        for (int k = 0; k < HW; k++) m[k] = (((k + 1) & (1 << j)) != 0);
        return m;
    endfunction

    logic [PAR_W-1:0]  syn_comb;
    logic              par_comb;
    logic [DATA_W-1:0] raw_data;
    logic [DATA_W-1:0] fixed_data;

    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_data_reg;
    logic [PAR_W-1:0]  s1_syn_reg;
    logic              s1_par_reg;

    logic              out_valid_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic              err_corrected_reg;
    logic              err_uncorrectable_reg;
    logic [PAR_W-1:0]  err_pos_reg;
    logic [CNT_W-1:0]  corr_count_reg;
    logic [CNT_W-1:0]  uncorr_count_reg;

    logic              flip_en;
    logic              corr_next;
    logic              uncorr_next;
    logic [PAR_W-1:0]  pos_next;
    logic              syn_nz;
    logic              syn_in_range;
    logic              s2_ready;
    logic              in_ready;
    logic              out_xfer;

    genvar gi;
    generate
        for (gi = 0; gi < PAR_W; gi++) begin : g_syn
            localparam logic [HW-1:0] MASK = syndrome_mask(gi);
            assign syn_comb[gi] = ^(bus.codeword_in[HW-1:0] & MASK);
        end

        if (EXT_PARITY != 0) begin : g_ext
            assign par_comb = ^bus.codeword_in;
        end else begin : g_no_ext
            assign par_comb = 1'b0;
        end

        // Only data positions need to survive stage 1; parity bits live on in S.
        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            localparam int POS = data_position(gi);
            assign raw_data[gi]   = bus.codeword_in[POS-1];
            assign fixed_data[gi] = s1_data_reg[gi] ^ (flip_en && (s1_syn_reg == PAR_W'(POS)));
        end
    endgenerate

    assign syn_nz       = |s1_syn_reg;
    assign syn_in_range = (s1_syn_reg <= HW_POS);

    always_comb begin
        flip_en     = 1'b0;
        corr_next   = 1'b0;
        uncorr_next = 1'b0;
        pos_next    = '0;
        if (!syn_in_range) begin
            uncorr_next = 1'b1;
        end else if (EXT_PARITY != 0) begin
            if (s1_par_reg) begin
                corr_next = 1'b1;
                if (syn_nz) begin
                    flip_en  = 1'b1;
                    pos_next = s1_syn_reg;
                end
            end else if (syn_nz) begin
                uncorr_next = 1'b1;
            end
        end else if (syn_nz) begin
            corr_next = 1'b1;
            flip_en   = 1'b1;
            pos_next  = s1_syn_reg;
        end
    end

    // in_ready looks only at registered state and out_ready, never in_valid.
    assign s2_ready = !out_valid_reg || bus.out_ready;
    assign in_ready = !s1_valid_reg || s2_ready;
    assign out_xfer = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_syn_reg   <= '0;
            s1_par_reg   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_reg <= raw_data;
                s1_syn_reg  <= syn_comb;
                s1_par_reg  <= par_comb;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg         <= 1'b0;
            data_out_reg          <= '0;
            err_corrected_reg     <= 1'b0;
            err_uncorrectable_reg <= 1'b0;
            err_pos_reg           <= '0;
        end else if (s2_ready) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                data_out_reg          <= fixed_data;
                err_corrected_reg     <= corr_next;
                err_uncorrectable_reg <= uncorr_next;
                err_pos_reg           <= pos_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count_reg   <= '0;
            uncorr_count_reg <= '0;
        end else if (bus.cnt_clr) begin
            corr_count_reg   <= '0;
            uncorr_count_reg <= '0;
        end else if (out_xfer) begin
            if (err_corrected_reg && !(&corr_count_reg))
                corr_count_reg <= corr_count_reg + CNT_W'(1);
            if (err_uncorrectable_reg && !(&uncorr_count_reg))
                uncorr_count_reg <= uncorr_count_reg + CNT_W'(1);
        end
    end

    assign bus.in_ready          = in_ready;
    assign bus.out_valid         = out_valid_reg;
    assign bus.data_out          = data_out_reg;
    assign bus.err_corrected     = err_corrected_reg;
    assign bus.err_uncorrectable = err_uncorrectable_reg;
    assign bus.err_pos           = err_pos_reg;
    assign bus.corr_count        = corr_count_reg;
    assign bus.uncorr_count      = uncorr_count_reg;
endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Bench for the pipelined SECDED decoder: directed vectors, backpressure,
// randomized streams against a position-XOR reference model, counters, reset.
module tb_hamming_secded_decoder_pipe;
    typedef struct packed {
        logic [10:0] d;
        logic        c;
        logic        u;
        logic [3:0]  pos;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_corr_a = 0;
    int   exp_uncorr_a = 0;

    always #5 clk = ~clk;

    hamming_secded_decoder_pipe_if #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(1), .CNT_W(16)) bus_a ();
    hamming_secded_decoder_pipe_if #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(1), .CNT_W(4))  bus_b ();
    hamming_secded_decoder_pipe_if #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(0), .CNT_W(16)) bus_c ();

    hamming_secded_decoder_pipe #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    hamming_secded_decoder_pipe #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    hamming_secded_decoder_pipe #(.DATA_W(11), .PAR_W(4), .EXT_PARITY(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c));

    // Encoder: data into non-power-of-two slots, each parity bit chosen so the
    // XOR of all set positions is zero, then optional even overall parity.
    function automatic logic [15:0] encode(input logic [10:0] d, input bit ext);
        logic [15:0] cw;
        int di;
        int s;
        cw = '0;
        di = 0;
        s  = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[di];
                if (d[di]) s = s ^ p;
                di++;
            end
        end
        for (int j = 0; j < 4; j++) cw[(1 << j) - 1] = s[j];
        if (ext) cw[15] = ^cw[14:0];
        return cw;
    endfunction

    function automatic exp_t model(input logic [15:0] cw, input bit ext);
        exp_t r;
        int s;
        bit p;
        int di;
        logic [15:0] f;
        s  = 0;
        p  = 1'b0;
        di = 0;
        f  = cw;
        r  = '0;
        for (int k = 0; k < 15; k++) begin
            if (cw[k]) begin
                s = s ^ (k + 1);
                p = ~p;
            end
        end
        if (ext) p = p ^ cw[15];
        else p = 1'b0;
        if (s > 15) begin
            r.u = 1'b1;
        end else if (ext) begin
            if (p) begin
                r.c = 1'b1;
                if (s != 0) begin
                    r.pos = 4'(s);
                    f[s-1] = ~f[s-1];
                end
            end else if (s != 0) begin
                r.u = 1'b1;
            end
        end else if (s != 0) begin
            r.c = 1'b1;
            r.pos = 4'(s);
            f[s-1] = ~f[s-1];
        end
        for (int q = 1; q <= 15; q++) begin
            if ((q & (q - 1)) != 0) begin
                r.d[di] = f[q-1];
                di++;
            end
        end
        return r;
    endfunction

    // Clean, single-flip, double-flip or arbitrary word in equal proportion.
    function automatic logic [15:0] make_word(input bit ext);
        logic [15:0] cw;
        int n;
        int a;
        int b;
        n  = ext ? 16 : 15;
        cw = encode(11'($urandom), ext);
        a  = $urandom_range(n - 1);
        b  = (a + 1 + $urandom_range(n - 2)) % n;
        case ($urandom_range(3))
            1: cw[a] = ~cw[a];
            2: begin
                cw[a] = ~cw[a];
                cw[b] = ~cw[b];
            end
            3: cw = 16'($urandom);
            default: ;
        endcase
        if (!ext) cw[15] = 1'b0;
        return cw;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_a.out_valid, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b d=%h c=%b u=%b pos=%0d, want all zero",
                     bus_a.out_valid, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos);
        end
        checks++;
        if (bus_a.corr_count !== 16'd0 || bus_a.uncorr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got corr=%0d uncorr=%0d, want 0 0", bus_a.corr_count, bus_a.uncorr_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, want 1", bus_a.in_ready);
        end
        $display("test_reset done");
    endtask

    task automatic send_directed(input string name, input logic [15:0] cw, input logic [10:0] ed,
                                 input logic ec, input logic eu, input logic [3:0] ep);
        @(negedge clk);
        bus_a.out_ready   = 1'b1;
        bus_a.in_valid    = 1'b1;
        bus_a.codeword_in = cw;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        checks++;
        if (bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency_early: out_valid=%b one cycle after accept, want 0", name, bus_a.out_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus_a.out_valid, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !==
            {1'b1, ed, ec, eu, ep}) begin
            errors++;
            $display("FAIL %s result: got valid=%b d=%h c=%b u=%b pos=%0d, want valid=1 d=%h c=%b u=%b pos=%0d",
                     name, bus_a.out_valid, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable,
                     bus_a.err_pos, ed, ec, eu, ep);
        end
        exp_corr_a   += int'(ec);
        exp_uncorr_a += int'(eu);
        @(negedge clk);
        checks++;
        if (bus_a.corr_count !== 16'(exp_corr_a) || bus_a.uncorr_count !== 16'(exp_uncorr_a)) begin
            errors++;
            $display("FAIL %s counters: got corr=%0d uncorr=%0d, want %0d %0d",
                     name, bus_a.corr_count, bus_a.uncorr_count, exp_corr_a, exp_uncorr_a);
        end
        $display("directed %s cw=%h -> d=%h c=%b u=%b pos=%0d", name, cw, ed, ec, eu, ep);
    endtask

    task automatic test_directed();
        send_directed("zero",    16'h0000, 11'h000, 1'b0, 1'b0, 4'd0);
        send_directed("ones",    16'hFFFF, 11'h7FF, 1'b0, 1'b0, 4'd0);
        send_directed("pos3",    16'h0004, 11'h000, 1'b1, 1'b0, 4'd3);
        send_directed("overall", 16'h7FFF, 11'h7FF, 1'b1, 1'b0, 4'd0);
        send_directed("double",  16'h0003, 11'h000, 1'b0, 1'b1, 4'd0);
    endtask

    task automatic test_backpressure();
        logic [15:0] w[4];
        exp_t q[$];
        exp_t e;
        exp_t snap;
        bit   have_snap;
        int   idx;
        int   got;
        have_snap = 1'b0;
        idx = 0;
        got = 0;
        for (int i = 0; i < 4; i++) w[i] = encode(11'(($urandom & 32'h7F8) | i), 1'b1);
        w[2][5] = ~w[2][5];
        bus_a.out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            bus_a.in_valid    = 1'b1;
            bus_a.codeword_in = w[idx];
            #1;
            if (bus_a.in_ready) begin
                q.push_back(model(w[idx], 1'b1));
                idx++;
            end
            if (bus_a.out_valid) begin
                if (!have_snap) begin
                    snap = {bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos};
                    have_snap = 1'b1;
                end else begin
                    checks++;
                    if ({bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== snap) begin
                        errors++;
                        $display("FAIL bp_stable: outputs changed under backpressure, got %h want %h",
                                 {bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos}, snap);
                    end
                end
            end
        end
        checks++;
        if (idx != 2 || bus_a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_capacity: accepted=%0d in_ready=%b, want 2 and 0", idx, bus_a.in_ready);
        end
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            bus_a.out_ready   = 1'b1;
            bus_a.in_valid    = (idx < 4);
            bus_a.codeword_in = w[idx % 4];
            #1;
            if (bus_a.in_valid && bus_a.in_ready) begin
                q.push_back(model(w[idx], 1'b1));
                idx++;
            end
            if (bus_a.out_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== e) begin
                    errors++;
                    $display("FAIL bp_order word %0d: got d=%h c=%b u=%b pos=%0d, want d=%h c=%b u=%b pos=%0d",
                             got, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos,
                             e.d, e.c, e.u, e.pos);
                end
                exp_corr_a   += int'(e.c);
                exp_uncorr_a += int'(e.u);
                got++;
            end
        end
        bus_a.in_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL bp_delivered: got %0d words, want 4", got);
        end
        $display("test_backpressure delivered %0d words", got);
    endtask

    task automatic test_random_stream(input int n);
        exp_t q[$];
        exp_t e;
        exp_t prev;
        bit   prev_hold;
        int   sent;
        int   got;
        sent = 0;
        got  = 0;
        prev_hold = 1'b0;
        prev = '0;
        for (int cyc = 0; cyc < 20 * n && got < n; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if ({bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== prev) begin
                    errors++;
                    $display("FAIL rand_stable: got %h, want held %h",
                             {bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos}, prev);
                end
            end
            bus_a.out_ready   = ($urandom_range(3) != 0);
            bus_a.in_valid    = (sent < n) && ($urandom_range(2) != 0);
            bus_a.codeword_in = make_word(1'b1);
            #1;
            prev_hold = bus_a.out_valid && !bus_a.out_ready;
            prev = {bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos};
            if (bus_a.in_valid && bus_a.in_ready) begin
                q.push_back(model(bus_a.codeword_in, 1'b1));
                sent++;
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== e) begin
                    errors++;
                    $display("FAIL rand_secded word %0d: got d=%h c=%b u=%b pos=%0d, want d=%h c=%b u=%b pos=%0d",
                             got, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos,
                             e.d, e.c, e.u, e.pos);
                end
                exp_corr_a   += int'(e.c);
                exp_uncorr_a += int'(e.u);
                got++;
            end
        end
        bus_a.in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL rand_secded_count: got %0d words, want %0d", got, n);
        end
        @(negedge clk);
        checks++;
        if (bus_a.corr_count !== 16'(exp_corr_a) || bus_a.uncorr_count !== 16'(exp_uncorr_a)) begin
            errors++;
            $display("FAIL rand_secded_counters: got corr=%0d uncorr=%0d, want %0d %0d",
                     bus_a.corr_count, bus_a.uncorr_count, exp_corr_a, exp_uncorr_a);
        end
        $display("test_random_stream %0d words, corr=%0d uncorr=%0d", got, exp_corr_a, exp_uncorr_a);
    endtask

    task automatic test_sec_stream(input int n);
        exp_t q[$];
        exp_t e;
        int   sent;
        int   got;
        int   ec;
        int   eu;
        sent = 0;
        got  = 0;
        ec   = 0;
        eu   = 0;
        for (int cyc = 0; cyc < 20 * n && got < n; cyc++) begin
            @(negedge clk);
            bus_c.out_ready   = ($urandom_range(3) != 0);
            bus_c.in_valid    = (sent < n) && ($urandom_range(2) != 0);
            bus_c.codeword_in = 15'(make_word(1'b0));
            #1;
            if (bus_c.in_valid && bus_c.in_ready) begin
                q.push_back(model({1'b0, bus_c.codeword_in}, 1'b0));
                sent++;
            end
            if (bus_c.out_valid && bus_c.out_ready) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({bus_c.data_out, bus_c.err_corrected, bus_c.err_uncorrectable, bus_c.err_pos} !== e) begin
                    errors++;
                    $display("FAIL rand_sec word %0d: got d=%h c=%b u=%b pos=%0d, want d=%h c=%b u=%b pos=%0d",
                             got, bus_c.data_out, bus_c.err_corrected, bus_c.err_uncorrectable, bus_c.err_pos,
                             e.d, e.c, e.u, e.pos);
                end
                ec += int'(e.c);
                eu += int'(e.u);
                got++;
            end
        end
        bus_c.in_valid = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL rand_sec_count: got %0d words, want %0d", got, n);
        end
        @(negedge clk);
        checks++;
        if (bus_c.corr_count !== 16'(ec) || bus_c.uncorr_count !== 16'(eu)) begin
            errors++;
            $display("FAIL rand_sec_counters: got corr=%0d uncorr=%0d, want %0d %0d",
                     bus_c.corr_count, bus_c.uncorr_count, ec, eu);
        end
        $display("test_sec_stream %0d words, corr=%0d uncorr=%0d", got, ec, eu);
    endtask

    task automatic test_saturation();
        logic [15:0] cw;
        int exp_b;
        int a;
        exp_t e;
        exp_b = 0;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cw = encode(11'($urandom), 1'b1);
            a  = $urandom_range(15);
            cw[a] = ~cw[a];
            e = model(cw, 1'b1);
            if (e.c && exp_b < 15) exp_b++;
            bus_b.in_valid    = 1'b1;
            bus_b.codeword_in = cw;
        end
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_b.corr_count !== 4'(exp_b) || bus_b.uncorr_count !== 4'd0) begin
            errors++;
            $display("FAIL sat_counter: got corr=%0d uncorr=%0d, want %0d 0",
                     bus_b.corr_count, bus_b.uncorr_count, exp_b);
        end
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            cw = encode(11'($urandom), 1'b1);
            cw[7] = ~cw[7];
            bus_b.in_valid    = 1'b1;
            bus_b.codeword_in = cw;
            @(negedge clk);
            bus_b.in_valid = 1'b0;
            for (int t = 0; t < 5 && !bus_b.out_valid; t++) @(negedge clk);
            checks++;
            if (bus_b.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat_timeout: out_valid=%b, want 1", bus_b.out_valid);
            end
            bus_b.cnt_clr = (round == 0);
            @(negedge clk);
            bus_b.cnt_clr = 1'b0;
            checks++;
            if (bus_b.corr_count !== 4'(round)) begin
                errors++;
                $display("FAIL sat_clear round %0d: got corr=%0d, want %0d", round, bus_b.corr_count, round);
            end
        end
        $display("test_saturation corr saturated at %0d, clear-wins checked", exp_b);
    endtask

    task automatic test_reset_midflight();
        int acc;
        acc = 0;
        bus_a.out_ready = 1'b0;
        for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
            @(negedge clk);
            bus_a.in_valid    = 1'b1;
            bus_a.codeword_in = make_word(1'b1);
            #1;
            if (bus_a.in_ready) acc++;
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus_a.out_valid, bus_a.data_out, bus_a.err_corrected, bus_a.err_uncorrectable, bus_a.err_pos} !== 18'h0 ||
            bus_a.corr_count !== 16'd0 || bus_a.uncorr_count !== 16'd0) begin
            errors++;
            $display("FAIL midreset_async: got valid=%b d=%h corr=%0d uncorr=%0d, want all zero",
                     bus_a.out_valid, bus_a.data_out, bus_a.corr_count, bus_a.uncorr_count);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_corr_a   = 0;
        exp_uncorr_a = 0;
        bus_a.out_ready = 1'b1;
        #1;
        checks++;
        if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: got in_ready=%b out_valid=%b, want 1 0", bus_a.in_ready, bus_a.out_valid);
        end
        send_directed("post_reset", 16'h0004, 11'h000, 1'b1, 1'b0, 4'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.in_valid = 1'b0; bus_a.codeword_in = '0; bus_a.out_ready = 1'b1; bus_a.cnt_clr = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.codeword_in = '0; bus_b.out_ready = 1'b1; bus_b.cnt_clr = 1'b0;
        bus_c.in_valid = 1'b0; bus_c.codeword_in = '0; bus_c.out_ready = 1'b1; bus_c.cnt_clr = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random_stream(300);
        test_sec_stream(200);
        test_saturation();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_secded_decoder_pipe.md
Name: hamming_secded_decoder_pipe

Overview:
- Parametrised, pipelined successor to the combinational (15,11) decoder.
- Decodes extended-Hamming (SECDED) codewords of arbitrary data width and reports correctable vs uncorrectable errors.
- Uses valid/ready handshakes on both sides, a 2-stage pipeline and saturating error counters.
- Sits between the channel/storage read path and the data consumer.

Parameters:
- DATA_W, 11, data bits per word.
- PAR_W, 4, Hamming parity bits; must satisfy 2^PAR_W >= DATA_W+PAR_W+1 (elaboration error otherwise).
- EXT_PARITY, 1, 1 = SECDED with extra overall parity bit; 0 = plain SEC.
- CNT_W, 16, width of each error counter.
- Derived: HW = DATA_W+PAR_W; CW_W = HW+EXT_PARITY.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder accepts codeword.
- codeword_in  in  CW_W  received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- data_out  out  DATA_W  corrected data.
- err_corrected  out  1  single error corrected in this word.
- err_uncorrectable  out  1  double or invalid-position error.
- err_pos  out  PAR_W  Hamming position (1..HW) of the corrected bit; 0 = overall parity bit or no error.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_count  out  CNT_W  corrected-word count.
- uncorr_count  out  CNT_W  uncorrectable-word count.

Behaviour:
- Codeword layout:
  - codeword_in[k], k<HW, is Hamming position k+1.
  - Parity bits sit at power-of-two positions.
  - Data bits fill the remaining positions in ascending order; data_out[0] is the lowest such position.
  - If EXT_PARITY, codeword_in[HW] is the even overall parity over bits 0..HW-1.
- Syndrome: S[j] = XOR of all Hamming bits whose position has bit j set. P = XOR of all CW_W bits (0 when EXT_PARITY=0).
- Classification with EXT_PARITY=1:
  - S=0, P=0: clean; no flags, err_pos=0.
  - S!=0, P=1, S<=HW: flip position S; err_corrected=1, err_pos=S.
  - S=0, P=1: overall parity bit in error; data unchanged, err_corrected=1, err_pos=0.
  - S!=0, P=0: double error; err_uncorrectable=1, data uncorrected, err_pos=0.
  - S>HW, any P: err_uncorrectable=1, no flip.
- Classification with EXT_PARITY=0:
  - S!=0, S<=HW: correct.
  - S>HW: uncorrectable.
  - Never reports uncorrectable for S<=HW.
- Error flags are mutually exclusive.
- Pipeline:
  - Stage 1 registers codeword, S and P on accept (in_valid && in_ready).
  - Stage 2 registers data_out, flags and err_pos.
  - Latency is 2 cycles from accept to out_valid with no backpressure.
  - Throughput is 1 word/cycle.
- Flow control:
  - Each stage advances when its successor is empty or accepting.
  - in_ready = !s1_valid || s2 advancing.
  - Holds up to 2 words under backpressure; no word is lost, duplicated or reordered.
  - in_ready is not combinationally dependent on in_valid.
- Output stability: while out_valid && !out_ready, all output data and flags hold stable.
- Counters:
  - On an output transfer (out_valid && out_ready), corr_count increments if err_corrected and uncorr_count increments if err_uncorrectable.
  - Both saturate at 2^CNT_W-1.
  - If cnt_clr and an increment occur in the same cycle, cnt_clr wins and the result is 0.
- Reset (async assert, mid-operation included):
  - Outputs: out_valid=0, data_out=0, err_corrected=0, err_uncorrectable=0, err_pos=0.
  - Counters: both=0.
  - Pipeline state: both stage valids=0; in-flight words are discarded.
  - in_ready reads 1 the first cycle after release.

Test Plan:
- Defaults (CW_W=16), out_ready=1, codeword 16'h0000 -> 2 cycles later data_out=11'h000, no flags, err_pos=0; 16'hFFFF -> data_out=11'h7FF, no flags.
- 16'h0004 (position 3 flipped) -> data_out=11'h000, err_corrected=1, err_pos=3, corr_count=1; 16'h7FFF -> data_out=11'h7FF, err_corrected=1, err_pos=0.
- 16'h0003 (positions 1,2 flipped) -> err_uncorrectable=1, err_corrected=0, uncorr_count=1.
- out_ready=0 for 6 cycles, in_valid=1 with 4 distinct words -> exactly 2 accepted, in_ready=0 afterwards, outputs stable; release out_ready -> all 4 delivered in order, none dropped.
- CNT_W=4, 20 single-error words -> corr_count=15; cnt_clr pulsed in the same cycle as an error transfer -> corr_count=0.
- rst asserted with 2 words in flight -> out_valid=0 immediately and counters=0; after release, next word returns with 2-cycle latency.
